// File: rtl/exe_stage_hs_pkg.sv
// Shared definitions for the exe_stage_hs execute stage.
// Covers FSM state encoding, rd-source and access-size codes, and byte-enable base patterns.
package exe_stage_hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_MC_DONE = 2'd2
  } exe_state_e;

  typedef enum logic [1:0] {
    TGT_EXEC = 2'd0,
    TGT_RSVD = 2'd1,
    TGT_ZERO = 2'd2,
    TGT_PC   = 2'd3
  } exe_target_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } exe_size_e;

  localparam logic [7:0] BE_BASE_BYTE  = 8'h01;
  localparam logic [7:0] BE_BASE_HALF  = 8'h03;
  localparam logic [7:0] BE_BASE_WORD  = 8'h0F;
  localparam logic [7:0] BE_BASE_DWORD = 8'hFF;

  function automatic logic [7:0] be_base(input logic [1:0] size);
    logic [7:0] base;
    case (size)
      SZ_BYTE:  base = BE_BASE_BYTE;
      SZ_HALF:  base = BE_BASE_HALF;
      SZ_WORD:  base = BE_BASE_WORD;
      SZ_DWORD: base = BE_BASE_DWORD;
      default:  base = 8'h00;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/exe_store_align.sv
// Store lane alignment: replicates the store operand across the bus and derives
// byte enables and the misalignment flag from access size and byte offset.
module exe_store_align
  import exe_stage_hs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int OFF_W      = $clog2(BE_WIDTH)
) (
  input  logic [1:0]            size,
  input  logic [OFF_W-1:0]      off,
  input  logic [DATA_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [BE_WIDTH-1:0]   be,
  output logic                  misalign
);

  logic [BE_WIDTH-1:0] base_s;

  // Lane replication and alignment check per access size
  always_comb begin
    wdata    = {DATA_WIDTH{1'b0}};
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata    = {BE_WIDTH{rs2[7:0]}};
        misalign = 1'b0;
      end
      SZ_HALF: begin
        wdata    = {(BE_WIDTH/2){rs2[15:0]}};
        misalign = off[0];
      end
      SZ_WORD: begin
        wdata    = {(BE_WIDTH/4){rs2[31:0]}};
        misalign = (off[1:0] != 2'b00);
      end
      SZ_DWORD: begin
        // a 32-bit bus cannot carry a dword in one beat
        wdata    = rs2;
        misalign = (DATA_WIDTH == 32) || (off != {OFF_W{1'b0}});
      end
      default: begin
        wdata    = {DATA_WIDTH{1'b0}};
        misalign = 1'b0;
      end
    endcase
  end

  assign base_s = BE_WIDTH'(be_base(size));
  assign be     = base_s << off;

endmodule

// File: rtl/exe_stage_hs.sv
// Execute stage with valid/ready handshakes, multi-cycle unit sequencing and the EX/MEM register.
// Optional: define EXE_STALL_CNT_EN to add the saturating mc_stall_cnt_o counter.
module exe_stage_hs
  import exe_stage_hs_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef EXE_STALL_CNT_EN
  output logic [31:0]               mc_stall_cnt_o,
`endif
  input  logic                      e_valid_i,
  output logic                      e_ready_o,
  input  logic                      e_flush_i,
  input  logic                      e_mc_op_i,
  input  logic [DATA_WIDTH-1:0]     e_rs1_i,
  input  logic [DATA_WIDTH-1:0]     e_rs2_i,
  input  logic [DATA_WIDTH-1:0]     e_imm_i,
  input  logic [DATA_WIDTH-1:0]     e_pc4_i,
  input  logic [DATA_WIDTH-1:0]     e_brj_pc_i,
  input  logic                      e_op2_imm_i,
  input  logic [1:0]                e_target_i,
  input  logic                      e_pc_sel_i,
  input  logic [REG_ADDR_WIDTH-1:0] e_regfile_waddr_i,
  input  logic                      e_regfile_wr_i,
  input  logic                      e_data_wr_i,
  input  logic                      e_data_rd_i,
  input  logic [1:0]                e_size_i,
  input  logic [2:0]                e_load_op_i,
  output logic [DATA_WIDTH-1:0]     op1_o,
  output logic [DATA_WIDTH-1:0]     op2_o,
  input  logic [DATA_WIDTH-1:0]     alu_res_i,
  output logic                      mc_start_o,
  output logic                      mc_kill_o,
  input  logic                      mc_done_i,
  input  logic [DATA_WIDTH-1:0]     mc_res_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] m_regfile_waddr_o,
  output logic                      m_regfile_wr_o,
  output logic [DATA_WIDTH-1:0]     m_regfile_rd_o,
  output logic [DATA_WIDTH-1:0]     m_data_addr_o,
  output logic [DATA_WIDTH-1:0]     m_data_wdata_o,
  output logic [BE_WIDTH-1:0]       m_data_be_o,
  output logic                      m_data_wr_o,
  output logic                      m_data_rd_o,
  output logic [2:0]                m_load_op_o,
  output logic                      m_misalign_o,
  output logic                      e_busy_o
);

  localparam int OFF_W = $clog2(BE_WIDTH);

  exe_state_e              state_r, state_nxt_s;
  logic                    slot_free_s, load_s, capture_s;
  logic                    e_ready_s, mc_start_s, mc_kill_s;
  logic [DATA_WIDTH-1:0]   hold_r, exec_res_s, rd_s;
  logic [DATA_WIDTH-1:0]   al_wdata_s;
  logic [BE_WIDTH-1:0]     al_be_s;
  logic                    al_mis_s, is_mem_s, mis_s;

  assign slot_free_s = !m_valid_o || m_ready_i;
  assign op1_o       = e_rs1_i;
  assign op2_o       = e_op2_imm_i ? e_imm_i : e_rs2_i;
  assign exec_res_s  = (state_r == ST_MC_DONE) ? hold_r : alu_res_i;
  assign e_ready_o   = e_ready_s;
  assign mc_start_o  = mc_start_s;
  assign mc_kill_o   = mc_kill_s;
  assign e_busy_o    = (state_r != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next state and handshake decode; flush overrides everything including mc_done_i
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    capture_s   = 1'b0;
    e_ready_s   = 1'b0;
    mc_start_s  = 1'b0;
    mc_kill_s   = 1'b0;
    if (e_flush_i) begin
      e_ready_s   = 1'b1;
      mc_kill_s   = (state_r == ST_MC_WAIT);
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (e_valid_i && e_mc_op_i) begin
            mc_start_s  = 1'b1;
            state_nxt_s = ST_MC_WAIT;
          end else if (e_valid_i && slot_free_s) begin
            load_s    = 1'b1;
            e_ready_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MC_WAIT: begin
          if (mc_done_i) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_MC_DONE;
          end else begin
            state_nxt_s = ST_MC_WAIT;
          end
        end
        ST_MC_DONE: begin
          if (slot_free_s) begin
            load_s      = 1'b1;
            e_ready_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_MC_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Holding register for the multi-cycle result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         hold_r <= {DATA_WIDTH{1'b0}};
    else if (capture_s) hold_r <= mc_res_i;
    else                hold_r <= hold_r;
  end

  exe_store_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .OFF_W      (OFF_W)
  ) u_align (
    .size     (e_size_i),
    .off      (exec_res_s[OFF_W-1:0]),
    .rs2      (e_rs2_i),
    .wdata    (al_wdata_s),
    .be       (al_be_s),
    .misalign (al_mis_s)
  );

  assign is_mem_s = e_data_wr_i || e_data_rd_i;
  assign mis_s    = is_mem_s && al_mis_s;

  // Register-file write value by target code
  always_comb begin
    rd_s = {DATA_WIDTH{1'b0}};
    case (e_target_i)
      TGT_EXEC:           rd_s = exec_res_s;
      TGT_RSVD, TGT_ZERO: rd_s = {DATA_WIDTH{1'b0}};
      TGT_PC:             rd_s = e_pc_sel_i ? e_pc4_i : e_brj_pc_i;
      default:            rd_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // EX/MEM boundary register; payload is only rewritten on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o         <= 1'b0;
      m_regfile_waddr_o <= {REG_ADDR_WIDTH{1'b0}};
      m_regfile_wr_o    <= 1'b0;
      m_regfile_rd_o    <= {DATA_WIDTH{1'b0}};
      m_data_addr_o     <= {DATA_WIDTH{1'b0}};
      m_data_wdata_o    <= {DATA_WIDTH{1'b0}};
      m_data_be_o       <= {BE_WIDTH{1'b0}};
      m_data_wr_o       <= 1'b0;
      m_data_rd_o       <= 1'b0;
      m_load_op_o       <= 3'd0;
      m_misalign_o      <= 1'b0;
    end else if (load_s) begin
      m_valid_o         <= 1'b1;
      m_regfile_waddr_o <= e_regfile_waddr_i;
      m_regfile_wr_o    <= e_regfile_wr_i && !mis_s;
      m_regfile_rd_o    <= rd_s;
      m_data_addr_o     <= exec_res_s;
      m_data_wdata_o    <= al_wdata_s;
      m_data_be_o       <= is_mem_s ? al_be_s : {BE_WIDTH{1'b0}};
      m_data_wr_o       <= e_data_wr_i && !mis_s;
      m_data_rd_o       <= e_data_rd_i && !mis_s;
      m_load_op_o       <= e_load_op_i;
      m_misalign_o      <= mis_s;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end else begin
      m_valid_o <= m_valid_o;
    end
  end

`ifdef EXE_STALL_CNT_EN
  // Saturating count of cycles an EX instruction is presented but not consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mc_stall_cnt_o <= 32'd0;
    else if (e_valid_i && !e_ready_s && (mc_stall_cnt_o != 32'hFFFF_FFFF))
      mc_stall_cnt_o <= mc_stall_cnt_o + 32'd1;
    else
      mc_stall_cnt_o <= mc_stall_cnt_o;
  end
`endif

endmodule

// File: tb/tb_exe_stage_hs.sv
// Self-checking bench for exe_stage_hs: randomized instructions against a behavioural model.
// Stall counter checks are active when EXE_STALL_CNT_EN is defined.
`timescale 1ns/1ps
module tb_exe_stage_hs;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          e_valid_i, e_ready_o, e_flush_i, e_mc_op_i;
  logic [DW-1:0] e_rs1_i, e_rs2_i, e_imm_i, e_pc4_i, e_brj_pc_i;
  logic          e_op2_imm_i, e_pc_sel_i, e_regfile_wr_i, e_data_wr_i, e_data_rd_i;
  logic [1:0]    e_target_i, e_size_i;
  logic [AW-1:0] e_regfile_waddr_i;
  logic [2:0]    e_load_op_i;
  logic [DW-1:0] op1_o, op2_o, alu_res_i, mc_res_i;
  logic          mc_start_o, mc_kill_o, mc_done_i;
  logic          m_valid_o, m_ready_i;
  logic [AW-1:0] m_regfile_waddr_o;
  logic          m_regfile_wr_o, m_data_wr_o, m_data_rd_o, m_misalign_o, e_busy_o;
  logic [DW-1:0] m_regfile_rd_o, m_data_addr_o, m_data_wdata_o;
  logic [BW-1:0] m_data_be_o;
  logic [2:0]    m_load_op_o;
`ifdef EXE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  exe_stage_hs #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef EXE_STALL_CNT_EN
    .mc_stall_cnt_o(stall_cnt),
`endif
    .e_valid_i(e_valid_i), .e_ready_o(e_ready_o), .e_flush_i(e_flush_i), .e_mc_op_i(e_mc_op_i),
    .e_rs1_i(e_rs1_i), .e_rs2_i(e_rs2_i), .e_imm_i(e_imm_i), .e_pc4_i(e_pc4_i),
    .e_brj_pc_i(e_brj_pc_i), .e_op2_imm_i(e_op2_imm_i), .e_target_i(e_target_i),
    .e_pc_sel_i(e_pc_sel_i), .e_regfile_waddr_i(e_regfile_waddr_i),
    .e_regfile_wr_i(e_regfile_wr_i), .e_data_wr_i(e_data_wr_i), .e_data_rd_i(e_data_rd_i),
    .e_size_i(e_size_i), .e_load_op_i(e_load_op_i), .op1_o(op1_o), .op2_o(op2_o),
    .alu_res_i(alu_res_i), .mc_start_o(mc_start_o), .mc_kill_o(mc_kill_o),
    .mc_done_i(mc_done_i), .mc_res_i(mc_res_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_regfile_waddr_o(m_regfile_waddr_o), .m_regfile_wr_o(m_regfile_wr_o),
    .m_regfile_rd_o(m_regfile_rd_o), .m_data_addr_o(m_data_addr_o),
    .m_data_wdata_o(m_data_wdata_o), .m_data_be_o(m_data_be_o), .m_data_wr_o(m_data_wr_o),
    .m_data_rd_o(m_data_rd_o), .m_load_op_o(m_load_op_o), .m_misalign_o(m_misalign_o),
    .e_busy_o(e_busy_o)
  );

  typedef struct packed {
    logic [DW-1:0] rd;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          rf_wr;
    logic          dwr;
    logic          drd;
    logic          mis;
    logic [AW-1:0] waddr;
    logic [2:0]    lop;
  } exp_t;

  // Expected EX/MEM payload for the instruction on the e_* inputs with execution result res
  function automatic exp_t model(input logic [DW-1:0] res);
    exp_t x;
    int nbytes, off;
    logic mem;
    nbytes = 1 << e_size_i;
    off    = int'(res % BW);
    mem    = e_data_wr_i | e_data_rd_i;
    x.mis  = mem && ((nbytes > BW) || ((off % nbytes) != 0));
    x.be   = '0;
    if (mem)
      for (int i = 0; i < BW; i++)
        if (i >= off && i < off + nbytes) x.be[i] = 1'b1;
    x.wdata = e_rs2_i;
    if (nbytes < BW)
      for (int i = 0; i < BW; i++) x.wdata[8*i +: 8] = e_rs2_i[8*(i % nbytes) +: 8];
    if (e_target_i == 2'd0)      x.rd = res;
    else if (e_target_i == 2'd3) x.rd = e_pc_sel_i ? e_pc4_i : e_brj_pc_i;
    else                         x.rd = '0;
    x.addr  = res;
    x.rf_wr = e_regfile_wr_i && !x.mis;
    x.dwr   = e_data_wr_i && !x.mis;
    x.drd   = e_data_rd_i && !x.mis;
    x.waddr = e_regfile_waddr_i;
    x.lop   = e_load_op_i;
    return x;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.rd = m_regfile_rd_o; o.addr = m_data_addr_o; o.wdata = m_data_wdata_o;
    o.be = m_data_be_o; o.rf_wr = m_regfile_wr_o; o.dwr = m_data_wr_o; o.drd = m_data_rd_o;
    o.mis = m_misalign_o; o.waddr = m_regfile_waddr_o; o.lop = m_load_op_o;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    e_valid_i = 1'b0; e_flush_i = 1'b0; e_mc_op_i = 1'b0; mc_done_i = 1'b0;
  endtask

  task automatic rand_fields();
    int mode;
    e_rs1_i = $urandom; e_rs2_i = $urandom; e_imm_i = $urandom;
    e_pc4_i = $urandom; e_brj_pc_i = $urandom; alu_res_i = $urandom; mc_res_i = $urandom;
    e_op2_imm_i = 1'($urandom); e_target_i = 2'($urandom); e_pc_sel_i = 1'($urandom);
    e_regfile_waddr_i = AW'($urandom); e_regfile_wr_i = 1'($urandom);
    mode = $urandom_range(0, 2);
    e_data_wr_i = (mode == 1); e_data_rd_i = (mode == 2);
    e_size_i = 2'($urandom); e_load_op_i = 3'($urandom);
  endtask

  task automatic test_reset();
    exp_t zero_x = '0;
    rst_n = 1'b0; set_idle(); rand_fields(); m_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid_o); end
    checks++; if (observed() !== zero_x) begin errors++; $display("FAIL reset_payload got %h exp 0", observed()); end
    checks++; if (e_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", e_busy_o); end
    checks++; if (mc_start_o !== 1'b0 || mc_kill_o !== 1'b0) begin errors++; $display("FAIL reset_mc got start %b kill %b exp 0 0", mc_start_o, mc_kill_o); end
`ifdef EXE_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    exp_t x;
    tick(); rand_fields();
    e_valid_i = 1'b1; e_target_i = 2'd0; e_data_wr_i = 1'b0; e_data_rd_i = 1'b0;
    alu_res_i = 32'h0000_0010; m_ready_i = 1'b1;
    #1;
    checks++; if (e_ready_o !== 1'b1) begin errors++; $display("FAIL add_e_ready got %b exp 1", e_ready_o); end
    checks++; if (op1_o !== e_rs1_i) begin errors++; $display("FAIL add_op1 got %h exp %h", op1_o, e_rs1_i); end
    x = model(alu_res_i);
    tick(); set_idle();
    checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL add_m_valid got %b exp 1", m_valid_o); end
    checks++; if (m_regfile_rd_o !== 32'h10) begin errors++; $display("FAIL add_rd got %h exp 10", m_regfile_rd_o); end
    checks++; if (observed() !== x) begin errors++; $display("FAIL add_payload got %h exp %h", observed(), x); end
    tick();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL add_m_valid_clear got %b exp 0", m_valid_o); end
  endtask

  task automatic test_back_to_back();
    exp_t prev;
    logic [DW-1:0] op2_x;
    bit have = 1'b0;
    m_ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (have) begin
        checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_m_valid[%0d] got %b exp 1", k, m_valid_o); end
        checks++; if (observed() !== prev) begin errors++; $display("FAIL b2b_payload[%0d] got %h exp %h", k, observed(), prev); end
      end
      rand_fields(); e_valid_i = 1'b1; e_mc_op_i = 1'b0; e_flush_i = 1'b0;
      op2_x = e_op2_imm_i ? e_imm_i : e_rs2_i;
      #1;
      checks++; if (e_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_e_ready[%0d] got %b exp 1", k, e_ready_o); end
      checks++; if (op2_o !== op2_x) begin errors++; $display("FAIL b2b_op2[%0d] got %h exp %h", k, op2_o, op2_x); end
      prev = model(alu_res_i); have = 1'b1;
    end
    tick(); set_idle();
    checks++; if (observed() !== prev) begin errors++; $display("FAIL b2b_last got %h exp %h", observed(), prev); end
  endtask

  task automatic test_store_align();
    logic [1:0]  sz_t [6] = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd2};
    logic [31:0] ad_t [6] = '{32'h103, 32'h102, 32'h101, 32'h102, 32'h100, 32'h104};
    logic        wr_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t x;
    m_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); rand_fields();
      e_valid_i = 1'b1; e_mc_op_i = 1'b0; e_target_i = 2'd0; alu_res_i = ad_t[i];
      e_size_i = sz_t[i]; e_data_wr_i = wr_t[i]; e_data_rd_i = !wr_t[i];
      e_rs2_i = 32'h1234_56AB; e_regfile_wr_i = 1'b1;
      x = model(alu_res_i);
      tick(); set_idle();
      checks++; if (observed() !== x) begin errors++; $display("FAIL align[%0d] got %h exp %h", i, observed(), x); end
      if (i == 0) begin
        checks++;
        if (m_data_wdata_o !== 32'hABAB_ABAB || m_data_be_o !== 4'b1000 || m_misalign_o !== 1'b0) begin
          errors++; $display("FAIL sb_103 got wdata %h be %b mis %b exp ababab ab 1000 0", m_data_wdata_o, m_data_be_o, m_misalign_o);
        end
      end
      if (i == 1) begin
        checks++;
        if (m_misalign_o !== 1'b1 || m_data_wr_o !== 1'b0 || m_data_be_o !== 4'hC) begin
          errors++; $display("FAIL sw_102 got mis %b wr %b be %h exp 1 0 c", m_misalign_o, m_data_wr_o, m_data_be_o);
        end
      end
    end
  endtask

  task automatic test_mc(input int lat, input logic [DW-1:0] res);
    exp_t x;
    tick(); set_idle(); m_ready_i = 1'b1; rand_fields(); e_mc_op_i = 1'b1;
    x = model(res);
    for (int c = 0; c <= lat + 2; c++) begin
      tick();
      checks++; if (e_busy_o !== (c >= 1 && c <= lat + 1)) begin errors++; $display("FAIL mc_busy c%0d got %b", c, e_busy_o); end
      checks++; if (m_valid_o !== (c == lat + 2)) begin errors++; $display("FAIL mc_m_valid c%0d got %b", c, m_valid_o); end
      if (c == lat + 2) begin
        checks++; if (observed() !== x) begin errors++; $display("FAIL mc_payload got %h exp %h", observed(), x); end
      end
      e_valid_i = (c <= lat + 1);
      mc_done_i = (c == lat);
      mc_res_i  = (c == lat) ? res : DW'($urandom);
      #1;
      checks++; if (mc_start_o !== (c == 0)) begin errors++; $display("FAIL mc_start c%0d got %b", c, mc_start_o); end
      checks++; if (e_ready_o !== (c == lat + 1)) begin errors++; $display("FAIL mc_e_ready c%0d got %b", c, e_ready_o); end
    end
    set_idle();
  endtask

  task automatic test_flush();
    exp_t x;
    tick(); set_idle(); m_ready_i = 1'b1; rand_fields();
    tick(); e_valid_i = 1'b1; e_mc_op_i = 1'b1; #1;
    checks++; if (mc_start_o !== 1'b1) begin errors++; $display("FAIL fl_start got %b exp 1", mc_start_o); end
    tick(); #1;
    checks++; if (e_busy_o !== 1'b1 || mc_kill_o !== 1'b0) begin errors++; $display("FAIL fl_wait got busy %b kill %b exp 1 0", e_busy_o, mc_kill_o); end
    tick(); e_flush_i = 1'b1; #1;
    checks++; if (mc_kill_o !== 1'b1 || e_ready_o !== 1'b1) begin errors++; $display("FAIL fl_kill got kill %b ready %b exp 1 1", mc_kill_o, e_ready_o); end
    tick();
    checks++; if (e_busy_o !== 1'b0) begin errors++; $display("FAIL fl_idle got %b exp 0", e_busy_o); end
    e_flush_i = 1'b0; e_valid_i = 1'b0; mc_done_i = 1'b1; mc_res_i = 32'h0000_DEAD; #1;
    checks++; if (mc_kill_o !== 1'b0) begin errors++; $display("FAIL fl_kill_once got %b exp 0", mc_kill_o); end
    tick(); mc_done_i = 1'b0;
    checks++; if (e_busy_o !== 1'b0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL fl_late_done got busy %b m_valid %b exp 0 0", e_busy_o, m_valid_o); end
    tick();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL fl_no_load got %b exp 0", m_valid_o); end
    // flush and done together: flush wins
    e_valid_i = 1'b1; e_mc_op_i = 1'b1;
    tick(); e_flush_i = 1'b1; mc_done_i = 1'b1; mc_res_i = $urandom; #1;
    checks++; if (mc_kill_o !== 1'b1) begin errors++; $display("FAIL fl_prio_kill got %b exp 1", mc_kill_o); end
    tick(); set_idle();
    checks++; if (e_busy_o !== 1'b0) begin errors++; $display("FAIL fl_prio_busy got %b exp 0", e_busy_o); end
    tick();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL fl_prio_m_valid got %b exp 0", m_valid_o); end
    // flush of a single-cycle instruction in IDLE
    e_valid_i = 1'b1; e_flush_i = 1'b1; #1;
    checks++; if (e_ready_o !== 1'b1 || mc_start_o !== 1'b0) begin errors++; $display("FAIL fl_alu got ready %b start %b exp 1 0", e_ready_o, mc_start_o); end
    tick(); set_idle();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL fl_alu_m_valid got %b exp 0", m_valid_o); end
    // registered instruction survives a flush
    rand_fields(); e_valid_i = 1'b1; x = model(alu_res_i);
    tick(); set_idle(); e_flush_i = 1'b1; m_ready_i = 1'b0;
    tick(); e_flush_i = 1'b0;
    checks++; if (m_valid_o !== 1'b1 || observed() !== x) begin errors++; $display("FAIL fl_keep got v %b %h exp 1 %h", m_valid_o, observed(), x); end
    m_ready_i = 1'b1;
    tick();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL fl_keep_drain got %b exp 0", m_valid_o); end
  endtask

  task automatic test_backpressure();
    exp_t xa, xb;
    tick(); set_idle(); rst_n = 1'b0; #2; rst_n = 1'b1;
    tick(); rand_fields(); e_valid_i = 1'b1; m_ready_i = 1'b1; xa = model(alu_res_i); #1;
    checks++; if (e_ready_o !== 1'b1) begin errors++; $display("FAIL bp_a_ready got %b exp 1", e_ready_o); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (m_valid_o !== 1'b1 || observed() !== xa) begin errors++; $display("FAIL bp_hold c%0d got v %b %h exp 1 %h", c, m_valid_o, observed(), xa); end
      if (c == 1) begin
        rand_fields(); e_valid_i = 1'b1; m_ready_i = 1'b0; xb = model(alu_res_i);
      end
      if (c == 4) begin
`ifdef EXE_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL bp_cnt got %0d exp 3", stall_cnt); end
`endif
        m_ready_i = 1'b1;
      end
      #1;
      checks++; if (e_ready_o !== (c == 4)) begin errors++; $display("FAIL bp_e_ready c%0d got %b", c, e_ready_o); end
    end
    tick(); set_idle();
    checks++; if (m_valid_o !== 1'b1 || observed() !== xb) begin errors++; $display("FAIL bp_b got v %b %h exp 1 %h", m_valid_o, observed(), xb); end
    tick();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", m_valid_o); end
  endtask

  task automatic test_reset_mid_mc();
    tick(); set_idle(); rand_fields(); e_valid_i = 1'b1; e_mc_op_i = 1'b1;
    tick(); tick();
    checks++; if (e_busy_o !== 1'b1) begin errors++; $display("FAIL rmc_busy got %b exp 1", e_busy_o); end
    set_idle(); rst_n = 1'b0; #1;
    checks++; if (e_busy_o !== 1'b0 || mc_kill_o !== 1'b0) begin errors++; $display("FAIL rmc_reset got busy %b kill %b exp 0 0", e_busy_o, mc_kill_o); end
    tick(); rst_n = 1'b1;
    tick();
    checks++; if (e_busy_o !== 1'b0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL rmc_after got busy %b v %b exp 0 0", e_busy_o, m_valid_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_store_align();
    test_mc(5, 32'h0000_0007);
    test_mc(1, DW'($urandom));
    test_mc($urandom_range(2, 8), DW'($urandom));
    test_flush();
    test_backpressure();
    test_reset_mid_mc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
